// File: rtl/id_operand_unit_pkg.sv
// id_operand_unit_pkg: shared widths and bus layouts for the ID operand path.
package id_operand_unit_pkg;
    localparam int NUM_RD_DEF  = 2;
    localparam int NUM_FWD_DEF = 3;
    localparam int REG_AW      = 5;
    localparam int SB_CNT_W    = 3;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } if_to_id_t;
    localparam int IF_TO_ID_W = $bits(if_to_id_t);
    // Forward bus field layout, MSB first: {we, waddr[4:0], wdata}
    function automatic int fwd_bus_w(int data_w);
        return 1 + REG_AW + data_w;
    endfunction
endpackage

// File: rtl/id_load_scoreboard.sv
// id_load_scoreboard: per-register load-latency counters with per-port busy lookup.
module id_load_scoreboard
    import id_operand_unit_pkg::*;
#(
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int LOAD_LAT = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     id_hold,
    input  logic                     issue_load,
    input  logic [REG_AW-1:0]        issue_waddr,
    input  logic [NUM_RD*REG_AW-1:0] raddr,
    output logic [NUM_RD-1:0]        busy
);
    logic [31:0][SB_CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else begin
            for (int i = 1; i < 32; i++)
                cnt[i] <= (issue_load && !id_hold && issue_waddr == REG_AW'(i)) ? SB_CNT_W'(LOAD_LAT)
                                                                                 : cnt[i] - SB_CNT_W'(cnt[i] != '0);
        end
    end
    always_comb begin
        busy = '0;
        for (int p = 0; p < NUM_RD; p++)
            busy[p] = cnt[raddr[p*REG_AW +: REG_AW]] != '0;
    end
endmodule

// File: rtl/id_operand_unit.sv
// id_operand_unit: IF->ID register, SRAM replay, operand forwarding and load-use stall.
// Optional stall counters are built when ID_STALL_PERF_EN is defined.
module id_operand_unit
    import id_operand_unit_pkg::*;
#(
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int NUM_FWD  = NUM_FWD_DEF,
    parameter int LOAD_LAT = 2,
    parameter int DATA_W   = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      id_hold,
    input  logic                      id_bubble,
    input  logic                      if_valid,
    input  logic [31:0]               if_pc,
    input  logic [31:0]               inst_sram_rdata,
    input  logic [NUM_RD*REG_AW-1:0]  raddr,
    input  logic [NUM_RD-1:0]         rd_used,
    input  logic [NUM_RD*DATA_W-1:0]  rf_rdata,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic                      issue_load,
    input  logic [REG_AW-1:0]         issue_waddr,
    output logic                      id_valid,
    output logic [31:0]               id_pc,
    output logic [31:0]               id_inst,
    output logic [NUM_RD*DATA_W-1:0]  opnd_data,
    output logic                      stallreq
`ifdef ID_STALL_PERF_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               load_stalls
`endif
);
    localparam int FW = fwd_bus_w(DATA_W);
    if_to_id_t                 id_q;
    logic [IF_TO_ID_W-1:0]     if_bus;
    logic                      buf_full;
    logic [31:0]               buf_inst;
    logic [NUM_RD-1:0]         busy;
    logic [FW-1:0]             fwd_bus [NUM_FWD];
    assign if_bus = {if_valid, if_pc};
    // The SRAM word is only valid for one cycle, so it is captured when a hold begins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_q     <= '0;
            buf_full <= 1'b0;
            buf_inst <= '0;
        end else begin
            if (!id_hold) id_q <= id_bubble ? '0 : if_to_id_t'(if_bus);
            if (id_hold && !buf_full) buf_inst <= inst_sram_rdata;
            buf_full <= id_hold;
        end
    end
    assign id_valid = id_q.valid;
    assign id_pc    = id_q.pc;
    assign id_inst  = !id_q.valid ? '0 : buf_full ? buf_inst : inst_sram_rdata;
    for (genvar f = 0; f < NUM_FWD; f++) begin : g_fwd
        assign fwd_bus[f] = {fwd_we[f], fwd_waddr[f*REG_AW +: REG_AW], fwd_wdata[f*DATA_W +: DATA_W]};
    end
    // Scan oldest to youngest so the youngest matching source lands last
    always_comb begin
        opnd_data = rf_rdata;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int f = NUM_FWD - 1; f >= 0; f--)
                if (fwd_bus[f][FW-1] && fwd_bus[f][DATA_W +: REG_AW] == raddr[p*REG_AW +: REG_AW])
                    opnd_data[p*DATA_W +: DATA_W] = fwd_bus[f][DATA_W-1:0];
            if (raddr[p*REG_AW +: REG_AW] == '0) opnd_data[p*DATA_W +: DATA_W] = '0;
        end
    end
    id_load_scoreboard #(.NUM_RD(NUM_RD), .LOAD_LAT(LOAD_LAT)) u_sb (
        .clk        (clk),
        .resetn     (resetn),
        .id_hold    (id_hold),
        .issue_load (issue_load),
        .issue_waddr(issue_waddr),
        .raddr      (raddr),
        .busy       (busy)
    );
    assign stallreq = id_q.valid && |(busy & rd_used);
`ifdef ID_STALL_PERF_EN
    logic stall_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q      <= 1'b0;
            stall_cycles <= '0;
            load_stalls  <= '0;
        end else begin
            stall_q <= stallreq;
            if (stallreq && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
            if (stallreq && !stall_q && !(&load_stalls)) load_stalls <= load_stalls + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_operand_unit.sv
// tb_id_operand_unit: directed vectors, a cycle-count based reference model and literal pins.
module tb_id_operand_unit;
    localparam int LOAD_LAT = 2;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        id_hold = 1'b0, id_bubble = 1'b0, if_valid = 1'b0;
    logic [31:0] if_pc = '0, inst_sram_rdata = '0;
    logic [9:0]  raddr = '0;
    logic [1:0]  rd_used = '0;
    logic [63:0] rf_rdata = '0;
    logic [2:0]  fwd_we = '0;
    logic [14:0] fwd_waddr = '0;
    logic [95:0] fwd_wdata = '0;
    logic        issue_load = 1'b0;
    logic [4:0]  issue_waddr = '0;
    logic        id_valid, stallreq;
    logic [31:0] id_pc, id_inst;
    logic [63:0] opnd_data;
    int checks = 0, failures = 0;

    id_operand_unit dut (
        .clk(clk), .resetn(resetn), .id_hold(id_hold), .id_bubble(id_bubble),
        .if_valid(if_valid), .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
        .raddr(raddr), .rd_used(rd_used), .rf_rdata(rf_rdata),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .issue_load(issue_load), .issue_waddr(issue_waddr),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .opnd_data(opnd_data), .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: a load makes its register unavailable until an absolute cycle number
    logic        m_valid = 1'b0, m_held = 1'b0;
    logic [31:0] m_pc = '0, m_held_inst = '0;
    int          m_cyc = 0;
    int          m_ready [32];
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_held  <= 1'b0;
            m_cyc   <= 0;
            for (int i = 0; i < 32; i++) m_ready[i] <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (!id_hold) begin
                m_valid <= id_bubble ? 1'b0 : if_valid;
                m_pc    <= id_bubble ? 32'd0 : if_pc;
            end
            m_held <= id_hold;
            if (id_hold && !m_held) m_held_inst <= inst_sram_rdata;
            if (issue_load && issue_waddr != 5'd0 && !id_hold) m_ready[issue_waddr] <= m_cyc + 1 + LOAD_LAT;
        end
    end

    function automatic logic [31:0] m_opnd(input int p);
        logic [4:0] ra = raddr[p*5 +: 5];
        if (ra == 5'd0) return 32'd0;
        for (int f = 0; f < 3; f++)
            if (fwd_we[f] && fwd_waddr[f*5 +: 5] == ra) return fwd_wdata[f*32 +: 32];
        return rf_rdata[p*32 +: 32];
    endfunction

    function automatic logic m_stall();
        logic s = 1'b0;
        for (int p = 0; p < 2; p++)
            if (m_valid && rd_used[p] && raddr[p*5 +: 5] != 5'd0 && m_cyc < m_ready[raddr[p*5 +: 5]]) s = 1'b1;
        return s;
    endfunction

    always @(negedge clk) begin
        check("cmp_valid", {31'd0, id_valid}, {31'd0, m_valid});
        check("cmp_pc", id_pc, m_pc);
        check("cmp_inst", id_inst, !m_valid ? 32'd0 : m_held ? m_held_inst : inst_sram_rdata);
        check("cmp_stall", {31'd0, stallreq}, {31'd0, m_stall()});
        check("cmp_opnd0", opnd_data[31:0], m_opnd(0));
        check("cmp_opnd1", opnd_data[63:32], m_opnd(1));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        logic s;
        tick();
        #1;
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_inst", id_inst, 32'd0);
        check("rst_stall", {31'd0, stallreq}, 32'd0);
        resetn = 1'b1;
        if_valid = 1'b1;
        if_pc = 32'h100;
        inst_sram_rdata = 32'h0000_0001;
        tick();
        // forwarding priority
        raddr[4:0] = 5'd5;
        rf_rdata[31:0] = 32'h99;
        fwd_waddr = {5'd5, 5'd5, 5'd5};
        fwd_wdata = {32'h33, 32'h22, 32'h11};
        fwd_we = 3'b111;
        #1 check("fwd_ex", opnd_data[31:0], 32'h11);
        fwd_we = 3'b110;
        #1 check("fwd_mem", opnd_data[31:0], 32'h22);
        fwd_we = 3'b100;
        #1 check("fwd_wb", opnd_data[31:0], 32'h33);
        fwd_we = 3'b000;
        #1 check("fwd_rf", opnd_data[31:0], 32'h99);
        // r0 guard
        fwd_we = 3'b001;
        fwd_waddr = '0;
        fwd_wdata = {64'd0, 32'hDEAD};
        raddr = '0;
        rf_rdata = {32'h0, 32'h77};
        #1 check("r0_opnd", opnd_data[31:0], 32'h0);
        check("r0_stall", {31'd0, stallreq}, 32'd0);
        fwd_we = '0;
        tick();
        // load-use on port 1
        issue_load = 1'b1;
        issue_waddr = 5'd8;
        tick();
        issue_load = 1'b0;
        raddr[9:5] = 5'd8;
        rd_used = 2'b10;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            #1 s = stallreq;
            if (s) n++;
            if (k == 0) check("lu_first", {31'd0, s}, 32'd1);
            if (k == 2) check("lu_release", {31'd0, s}, 32'd0);
            id_hold = s;
            tick();
        end
        check("lu_count", n, 32'd2);
        fwd_we = 3'b010;
        fwd_waddr = {5'd0, 5'd8, 5'd0};
        fwd_wdata = {32'h0, 32'hCAFE, 32'h0};
        rf_rdata = {32'h5555, 32'h0};
        #1 check("lu_opnd", opnd_data[63:32], 32'hCAFE);
        fwd_we = '0;
        tick();
        // unused port never stalls
        issue_load = 1'b1;
        tick();
        issue_load = 1'b0;
        rd_used = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1 check("unused_port", {31'd0, stallreq}, 32'd0);
            tick();
        end
        raddr = '0;
        // replay across a three-cycle hold
        if_pc = 32'h200;
        inst_sram_rdata = 32'h2408000A;
        tick();
        #1 check("rp_live", id_inst, 32'h2408000A);
        id_hold = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            inst_sram_rdata = 32'hBAD0_0000 + k;
            #1 check("rp_hold", id_inst, 32'h2408000A);
        end
        id_hold = 1'b0;
        if_pc = 32'h204;
        tick();
        inst_sram_rdata = 32'h3C010001;
        #1 check("rp_after", id_inst, 32'h3C010001);
        check("rp_pc", id_pc, 32'h204);
        // hold beats bubble, then bubble
        id_hold = 1'b1;
        id_bubble = 1'b1;
        tick();
        #1 check("hold_over_bubble", {31'd0, id_valid}, 32'd1);
        id_hold = 1'b0;
        tick();
        #1 check("bubble_valid", {31'd0, id_valid}, 32'd0);
        check("bubble_inst", id_inst, 32'd0);
        id_bubble = 1'b0;
        tick();
        // asynchronous reset in the middle of a stall
        issue_load = 1'b1;
        issue_waddr = 5'd9;
        tick();
        issue_load = 1'b0;
        raddr[4:0] = 5'd9;
        rd_used = 2'b01;
        #1 check("mid_stall", {31'd0, stallreq}, 32'd1);
        id_hold = 1'b1;
        #1 resetn = 1'b0;
        #1 check("async_stall", {31'd0, stallreq}, 32'd0);
        check("async_valid", {31'd0, id_valid}, 32'd0);
        #1 resetn = 1'b1;
        id_hold = 1'b0;
        tick();
        #1 check("sb_cleared", {31'd0, stallreq}, 32'd0);
        check("reload_valid", {31'd0, id_valid}, 32'd1);
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
